// File: rtl/ps2_note_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_pkg
// Brief    : Shared types, scan-code constants and the note map for the
//            PS/2 note keyboard receiver.
// Revision : 2.0
// ============================================================================
package ps2_note_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] C_SC_EXT    = 8'hE0;
    localparam logic [7:0] C_SC_BRK    = 8'hF0;
    localparam logic [7:0] C_SC_BAT    = 8'hAA;
    localparam logic [7:0] C_SC_ERR_FF = 8'hFF;
    localparam logic [7:0] C_SC_ERR_00 = 8'h00;
    localparam logic [7:0] C_SC_OCT_DN = 8'h1A;
    localparam logic [7:0] C_SC_OCT_UP = 8'h22;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } note_t;

    // Piano-style layout: home row = white keys, upper row = black keys.
    function automatic note_t note_map(input logic [7:0] code);
        note_t r;
        r.hit = 1'b1;
        r.idx = 5'd0;
        case (code)
            8'h1C:   r.idx = 5'd0;
            8'h1D:   r.idx = 5'd1;
            8'h1B:   r.idx = 5'd2;
            8'h24:   r.idx = 5'd3;
            8'h23:   r.idx = 5'd4;
            8'h2B:   r.idx = 5'd5;
            8'h2C:   r.idx = 5'd6;
            8'h34:   r.idx = 5'd7;
            8'h35:   r.idx = 5'd8;
            8'h33:   r.idx = 5'd9;
            8'h3C:   r.idx = 5'd10;
            8'h3B:   r.idx = 5'd11;
            8'h42:   r.idx = 5'd12;
            8'h44:   r.idx = 5'd13;
            8'h4B:   r.idx = 5'd14;
            8'h4D:   r.idx = 5'd15;
            8'h4C:   r.idx = 5'd16;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 pin synchronizers, clock run filter, 11-bit frame FSM
//            and inter-edge timeout.
// Revision : 2.0
// ============================================================================
module ps2_frame_rx
    import ps2_note_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILT_LEN);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]     clk_sync_q;
    logic [1:0]     dat_sync_q;
    logic           filt_q,  filt_d;
    logic [FCW-1:0] fcnt_q,  fcnt_d;
    rx_state_t      state_q, state_d;
    logic [2:0]     bcnt_q,  bcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q,   par_d;
    logic [TOW-1:0] tcnt_q,  tcnt_d;
    logic           bv_q,    bv_d;
    logic [7:0]     bdata_q, bdata_d;
    logic           ferr_q,  ferr_d;

    logic w_clk_s;
    logic w_dat_s;
    logic w_strobe;
    logic w_timeout;

    assign w_clk_s = clk_sync_q[1];
    assign w_dat_s = dat_sync_q[1];

    always_ff @(posedge clk) begin
        if (ar) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            bv_q       <= 1'b0;
            bdata_q    <= '0;
            ferr_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            bv_q       <= bv_d;
            bdata_q    <= bdata_d;
            ferr_q     <= ferr_d;
        end
    end

    // The filtered level flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (w_clk_s != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = w_clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign w_strobe  = filt_q & ~filt_d;
    assign w_timeout = (state_q != IDLE) && (tcnt_q == TOW'(TIMEOUT_CYC));

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        bv_d    = 1'b0;
        bdata_d = bdata_q;
        ferr_d  = 1'b0;

        if (state_q == IDLE || w_strobe) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (w_timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tcnt_d  = '0;
        end else if (w_strobe) begin
            case (state_q)
                IDLE: begin
                    if (!w_dat_s) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    shift_d = {w_dat_s, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = w_dat_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (w_dat_s && (^{shift_q, par_q})) begin
                        bv_d    = 1'b1;
                        bdata_d = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_valid = bv_q;
    assign byte_data  = bdata_q;
    assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/ps2_note_kbd.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_kbd
// Brief    : PS/2 keyboard to held-note mask, key events and octave register.
// Revision : 2.0
// ============================================================================
module ps2_note_kbd
    import ps2_note_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int NUM_KEYS    = 17,
    parameter int OCT_INIT    = 4,
    parameter int OCT_MAX     = 7
) (
    input  logic                clk,
    input  logic                ar,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    output logic [NUM_KEYS-1:0] key_mask,
    output logic [2:0]          octave,
    output logic                evt_valid,
    output logic [4:0]          evt_key,
    output logic                evt_press,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    output logic                frame_err
);

    localparam logic [2:0]          C_OCT_INIT = 3'(OCT_INIT);
    localparam logic [2:0]          C_OCT_MAX  = 3'(OCT_MAX);
    localparam logic [NUM_KEYS-1:0] C_ONE      = NUM_KEYS'(1);

    logic                rx_valid;
    logic [7:0]          rx_byte;

    logic [NUM_KEYS-1:0] key_mask_q,  key_mask_d;
    logic [2:0]          octave_q,    octave_d;
    logic                ext_q,       ext_d;
    logic                brk_q,       brk_d;
    logic                evt_valid_q, evt_valid_d;
    logic [4:0]          evt_key_q,   evt_key_d;
    logic                evt_press_q, evt_press_d;

    note_t               w_note;
    logic [NUM_KEYS-1:0] w_onehot;
    logic                w_held;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .ar         (ar),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (ar) begin
            key_mask_q  <= '0;
            octave_q    <= C_OCT_INIT;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_press_q <= 1'b0;
        end else begin
            key_mask_q  <= key_mask_d;
            octave_q    <= octave_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_press_q <= evt_press_d;
        end
    end

    // Indices beyond NUM_KEYS shift out of the one-hot and are dropped naturally.
    assign w_note   = note_map(rx_byte);
    assign w_onehot = C_ONE << w_note.idx;
    assign w_held   = |(key_mask_q & w_onehot);

    always_comb begin
        key_mask_d  = key_mask_q;
        octave_d    = octave_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        evt_valid_d = 1'b0;
        evt_key_d   = evt_key_q;
        evt_press_d = evt_press_q;

        if (rx_valid) begin
            if (rx_byte == C_SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == C_SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (rx_byte == C_SC_BAT || rx_byte == C_SC_ERR_FF ||
                    rx_byte == C_SC_ERR_00) begin
                    key_mask_d = '0;
                end else if (!ext_q) begin
                    if (w_note.hit && (w_onehot != '0)) begin
                        if (!brk_q && !w_held) begin
                            key_mask_d  = key_mask_q | w_onehot;
                            evt_valid_d = 1'b1;
                            evt_key_d   = w_note.idx;
                            evt_press_d = 1'b1;
                        end else if (brk_q && w_held) begin
                            key_mask_d  = key_mask_q & ~w_onehot;
                            evt_valid_d = 1'b1;
                            evt_key_d   = w_note.idx;
                            evt_press_d = 1'b0;
                        end
                    end else if (!brk_q && rx_byte == C_SC_OCT_DN &&
                                 octave_q != 3'd0) begin
                        octave_d = octave_q - 1'b1;
                    end else if (!brk_q && rx_byte == C_SC_OCT_UP &&
                                 octave_q < C_OCT_MAX) begin
                        octave_d = octave_q + 1'b1;
                    end
                end
            end
        end
    end

    assign key_mask   = key_mask_q;
    assign octave     = octave_q;
    assign evt_valid  = evt_valid_q;
    assign evt_key    = evt_key_q;
    assign evt_press  = evt_press_q;
    assign byte_valid = rx_valid;
    assign byte_data  = rx_byte;

endmodule
`default_nettype wire

// File: tb/tb_ps2_note_kbd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_note_kbd
// Brief    : Self-checking bench for ps2_note_kbd with a byte-level model.
// Revision : 2.0
// ============================================================================
module tb_ps2_note_kbd;

    localparam int FILT = 8;
    localparam int TO   = 2000;

    logic clk = 1'b0;
    logic ar = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    always #5 clk = ~clk;

    logic [16:0] km17;
    logic [11:0] km12;
    logic [2:0]  oct17, oct12;
    logic        ev17, ev12, pr17, pr12;
    logic [4:0]  ek17, ek12;
    logic        bv17, bv12, fe17, fe12;
    logic [7:0]  bd17, bd12;

    ps2_note_kbd #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO), .NUM_KEYS(17),
                   .OCT_INIT(4), .OCT_MAX(7)) u_dut (
        .clk(clk), .ar(ar), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_mask(km17), .octave(oct17), .evt_valid(ev17), .evt_key(ek17),
        .evt_press(pr17), .byte_valid(bv17), .byte_data(bd17), .frame_err(fe17)
    );

    ps2_note_kbd #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO), .NUM_KEYS(12),
                   .OCT_INIT(4), .OCT_MAX(7)) u_dut12 (
        .clk(clk), .ar(ar), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_mask(km12), .octave(oct12), .evt_valid(ev12), .evt_key(ek12),
        .evt_press(pr12), .byte_valid(bv12), .byte_data(bd12), .frame_err(fe12)
    );

    int n_vec = 0;
    int n_err = 0;
    int nbv = 0;
    int nfe = 0;

    logic [5:0] got17[$], got12[$], exp17[$], exp12[$];

    // Reference model state
    logic [16:0] m_mask17;
    logic [11:0] m_mask12;
    int          m_oct;
    bit          m_ext, m_brk;
    logic [7:0]  m_last;

    logic [7:0] note_codes [17] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                    8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B,
                                    8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C};

    always @(negedge clk) begin
        if (ev17) got17.push_back({ek17, pr17});
        if (ev12) got12.push_back({ek12, pr12});
        if (bv17) nbv++;
        if (fe17) nfe++;
    end

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 17; i++) if (note_codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mask17 = '0; m_mask12 = '0; m_oct = 4; m_ext = 0; m_brk = 0; m_last = 8'h00;
        got17.delete(); got12.delete(); exp17.delete(); exp12.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        m_last = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'hAA || b == 8'hFF || b == 8'h00) begin
                m_mask17 = '0; m_mask12 = '0;
            end else if (!m_ext) begin
                k = lookup(b);
                if (k >= 0) begin
                    if (!m_brk && !m_mask17[k]) begin m_mask17[k] = 1'b1; exp17.push_back({5'(k), 1'b1}); end
                    if ( m_brk &&  m_mask17[k]) begin m_mask17[k] = 1'b0; exp17.push_back({5'(k), 1'b0}); end
                    if (k < 12) begin
                        if (!m_brk && !m_mask12[k]) begin m_mask12[k] = 1'b1; exp12.push_back({5'(k), 1'b1}); end
                        if ( m_brk &&  m_mask12[k]) begin m_mask12[k] = 1'b0; exp12.push_back({5'(k), 1'b0}); end
                    end
                end else if (!m_brk && b == 8'h1A) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
                else if (!m_brk && b == 8'h22) m_oct = (m_oct < 7) ? m_oct + 1 : 7;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Emits nclk clock pulses of an 11-bit frame; optional 3-cycle clock glitch in bit 4.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                              input int nclk, input bit glitch);
        logic [10:0] bits;
        int hp;
        hp = $urandom_range(12, 22);
        bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nclk; i++) begin
            repeat (hp / 2) @(negedge clk);
            ps2_dat = bits[i];
            repeat (hp / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b1;
            if (glitch && i == 4) begin
                repeat (2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
        repeat (hp) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (2 * hp + $urandom_range(0, 20)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0);
        model_byte(b);
    endtask

    task automatic test_reset();
        ar = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (km17 !== 17'h0) begin n_err++; $display("FAIL reset key_mask got %h exp 0", km17); end
        n_vec++; if (oct17 !== 3'd4) begin n_err++; $display("FAIL reset octave got %0d exp 4", oct17); end
        n_vec++; if ({ev17, bv17, fe17} !== 3'b000) begin n_err++; $display("FAIL reset pulses got %b exp 000", {ev17, bv17, fe17}); end
        n_vec++; if (bd17 !== 8'h00) begin n_err++; $display("FAIL reset byte_data got %h exp 00", bd17); end
        ar = 1'b0;
        model_reset();
        nbv = 0; nfe = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_press_release();
        send_byte(8'h1C);
        n_vec++; if (km17 !== 17'h00001) begin n_err++; $display("FAIL pr_make key_mask got %h exp 00001", km17); end
        n_vec++; if (bd17 !== 8'h1C) begin n_err++; $display("FAIL pr_make byte_data got %h exp 1c", bd17); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_vec++; if (km17 !== 17'h0) begin n_err++; $display("FAIL pr_break key_mask got %h exp 0", km17); end
        n_vec++; if (got17.size() != 2 || got17.size() != exp17.size()) begin
            n_err++; $display("FAIL pr_events count got %0d exp 2", got17.size());
        end else for (int i = 0; i < 2; i++) begin
            n_vec++; if (got17[i] !== exp17[i]) begin n_err++; $display("FAIL pr_event%0d got %h exp %h", i, got17[i], exp17[i]); end
        end
        n_vec++; if (nbv != 3) begin n_err++; $display("FAIL pr_byte_valid count got %0d exp 3", nbv); end
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
    endtask

    task automatic test_chord();
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'h23, 8'hF0, 8'h1C};
        for (int i = 0; i < 6; i++) send_byte(seq[i]);
        n_vec++; if (km17 !== 17'h00010 || km17 !== m_mask17) begin n_err++; $display("FAIL chord key_mask got %h exp 00010", km17); end
        n_vec++; if (got17.size() != 3 || got17.size() != exp17.size()) begin
            n_err++; $display("FAIL chord events count got %0d exp 3", got17.size());
        end else for (int i = 0; i < 3; i++) begin
            n_vec++; if (got17[i] !== exp17[i]) begin n_err++; $display("FAIL chord event%0d got %h exp %h", i, got17[i], exp17[i]); end
        end
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
    endtask

    task automatic test_bad_frames();
        int bv0, fe0;
        bv0 = nbv; fe0 = nfe;
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        n_vec++; if (nfe != fe0 + 1 || nbv != bv0) begin n_err++; $display("FAIL bad_parity err/bv got %0d/%0d exp %0d/%0d", nfe, nbv, fe0 + 1, bv0); end
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        n_vec++; if (nfe != fe0 + 2 || nbv != bv0) begin n_err++; $display("FAIL bad_stop err/bv got %0d/%0d exp %0d/%0d", nfe, nbv, fe0 + 2, bv0); end
        n_vec++; if (km17 !== m_mask17 || got17.size() != 0) begin n_err++; $display("FAIL bad_keep key_mask got %h exp %h", km17, m_mask17); end
        send_frame(8'h1C, 1'b0, 1'b0, 5, 1'b0);
        n_vec++; if (nfe != fe0 + 2) begin n_err++; $display("FAIL early_timeout err got %0d exp %0d", nfe, fe0 + 2); end
        repeat (TO + 60) @(negedge clk);
        n_vec++; if (nfe != fe0 + 3 || nbv != bv0) begin n_err++; $display("FAIL timeout err/bv got %0d/%0d exp %0d/%0d", nfe, nbv, fe0 + 3, bv0); end
        send_byte(8'hF0);
        send_byte(8'h23);
        n_vec++; if (km17 !== m_mask17 || km17 !== 17'h0) begin n_err++; $display("FAIL after_timeout key_mask got %h exp 0", km17); end
        n_vec++; if (got17.size() != 1 || got17[0] !== exp17[0]) begin n_err++; $display("FAIL after_timeout events got %0d exp 1", got17.size()); end
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
    endtask

    task automatic test_ext_glitch();
        int bv0;
        logic [7:0] seq [5] = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C};
        for (int i = 0; i < 5; i++) send_byte(seq[i]);
        n_vec++; if (km17 !== 17'h0 || got17.size() != 0) begin n_err++; $display("FAIL ext key_mask got %h events %0d exp 0/0", km17, got17.size()); end
        bv0 = nbv;
        send_frame(8'h2C, 1'b0, 1'b0, 11, 1'b1);
        model_byte(8'h2C);
        n_vec++; if (nbv != bv0 + 1 || bd17 !== 8'h2C) begin n_err++; $display("FAIL glitch byte got %h count %0d exp 2c %0d", bd17, nbv - bv0, 1); end
        n_vec++; if (km17 !== m_mask17) begin n_err++; $display("FAIL glitch key_mask got %h exp %h", km17, m_mask17); end
        send_byte(8'hF0); send_byte(8'h2C);
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
    endtask

    task automatic test_octave();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h22);
            n_vec++; if (oct17 !== 3'(m_oct)) begin n_err++; $display("FAIL oct_up%0d got %0d exp %0d", i, oct17, m_oct); end
        end
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h1A);
            n_vec++; if (oct17 !== 3'(m_oct)) begin n_err++; $display("FAIL oct_dn%0d got %0d exp %0d", i, oct17, m_oct); end
        end
        send_byte(8'hF0); send_byte(8'h22);
        n_vec++; if (oct17 !== 3'd0 || km17 !== m_mask17) begin n_err++; $display("FAIL oct_break got %0d exp 0", oct17); end
    endtask

    task automatic test_num_keys_bat();
        send_byte(8'h4C);
        n_vec++; if (got12.size() != 0 || km12 !== 12'h0) begin n_err++; $display("FAIL nk12 events got %0d exp 0", got12.size()); end
        n_vec++; if (km17 !== 17'h10000) begin n_err++; $display("FAIL nk17 key_mask got %h exp 10000", km17); end
        send_byte(8'hF0); send_byte(8'h4C);
        send_byte(8'h1C); send_byte(8'h23);
        n_vec++; if (km17 !== 17'h00011) begin n_err++; $display("FAIL bat_pre key_mask got %h exp 00011", km17); end
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
        send_byte(8'hAA);
        n_vec++; if (km17 !== 17'h0 || km12 !== 12'h0 || got17.size() != 0) begin n_err++; $display("FAIL bat key_mask got %h events %0d exp 0/0", km17, got17.size()); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h1C);
        send_byte(8'h22);
        send_frame(8'h23, 1'b0, 1'b0, 6, 1'b0);
        ar = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (km17 !== 17'h0 || oct17 !== 3'd4 || bd17 !== 8'h00) begin
            n_err++; $display("FAIL midreset got mask %h oct %0d byte %h exp 0/4/00", km17, oct17, bd17);
        end
        ar = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        send_byte(8'h1D);
        n_vec++; if (km17 !== 17'h00002 || got17.size() != 1) begin n_err++; $display("FAIL midreset_next key_mask got %h exp 00002", km17); end
        got17.delete(); exp17.delete(); got12.delete(); exp12.delete();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) b = note_codes[$urandom_range(0, 16)];
            else if (r < 7) b = 8'hF0;
            else if (r == 7) b = ($urandom_range(0, 1) != 0) ? 8'h1A : 8'h22;
            else if (r == 8) b = 8'hE0;
            else b = 8'($urandom_range(1, 255));
            send_byte(b);
        end
        n_vec++; if (km17 !== m_mask17) begin n_err++; $display("FAIL rand key_mask got %h exp %h", km17, m_mask17); end
        n_vec++; if (km12 !== m_mask12) begin n_err++; $display("FAIL rand key_mask12 got %h exp %h", km12, m_mask12); end
        n_vec++; if (oct17 !== 3'(m_oct)) begin n_err++; $display("FAIL rand octave got %0d exp %0d", oct17, m_oct); end
        n_vec++; if (bd17 !== m_last) begin n_err++; $display("FAIL rand byte_data got %h exp %h", bd17, m_last); end
        n_vec++; if (got17.size() != exp17.size()) begin
            n_err++; $display("FAIL rand events count got %0d exp %0d", got17.size(), exp17.size());
        end else for (int i = 0; i < exp17.size(); i++) begin
            n_vec++; if (got17[i] !== exp17[i]) begin n_err++; $display("FAIL rand event%0d got %h exp %h", i, got17[i], exp17[i]); end
        end
        n_vec++; if (got12.size() != exp12.size()) begin
            n_err++; $display("FAIL rand events12 count got %0d exp %0d", got12.size(), exp12.size());
        end else for (int i = 0; i < exp12.size(); i++) begin
            n_vec++; if (got12[i] !== exp12[i]) begin n_err++; $display("FAIL rand event12_%0d got %h exp %h", i, got12[i], exp12[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_chord();
        test_bad_frames();
        test_ext_glitch();
        test_octave();
        test_num_keys_bat();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
